// File: rtl/as_ctrl_seq.sv
// Instruction sequencer for the accumulator ALU: fetch / execute / MACN repeat / halt.
// State and instruction registers are clocked; control outputs decode from state, op and inputs.
module as_ctrl_seq #(
    parameter int n  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          run,
    input  logic          instr_valid,
    input  logic [3:0]    opcode,
    input  logic [CW-1:0] rpt,
    input  logic          z,
    output logic          instr_req,
    output logic          ir_load,
    output logic          pc_incr,
    output logic          pc_load,
    output logic          reg_we,
    output logic          add_a_sel,
    output logic          add_b_sel,
    output logic          acc_en,
    output logic          acc_add,
    output logic          in_en,
    output logic          rs_step,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_REPEAT = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_IN   = 4'd3;
    localparam logic [3:0] OP_BRZ  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_MACN = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t        r_state;
    logic [3:0]    r_op;
    logic [CW-1:0] r_cnt;

    // Datapath width is not used by the sequencer; kept for parameter compatibility.
    logic [n-1:0]  w_unused_dw;
    assign w_unused_dw = '0;

    logic w_cnt_nz;
    logic w_cnt_last;
    assign w_cnt_nz   = (r_cnt != '0);
    assign w_cnt_last = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (instr_valid) begin
                        r_op    <= opcode;
                        r_cnt   <= rpt;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (r_op == OP_MACN && w_cnt_nz) begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= w_cnt_last ? S_FETCH : S_REPEAT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_REPEAT: begin
                    // cnt never reaches zero here in normal flow; the guard keeps it from wrapping
                    if (w_cnt_nz) r_cnt <= r_cnt - 1'b1;
                    if (!w_cnt_nz || w_cnt_last) r_state <= S_FETCH;
                end
                S_HALT: begin
                    if (!run) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        instr_req = 1'b0;
        ir_load   = 1'b0;
        pc_incr   = 1'b0;
        pc_load   = 1'b0;
        reg_we    = 1'b0;
        add_a_sel = 1'b0;
        add_b_sel = 1'b0;
        acc_en    = 1'b0;
        acc_add   = 1'b0;
        in_en     = 1'b0;
        rs_step   = 1'b0;
        busy      = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_REPEAT);
        halted    = (r_state == S_HALT);
        case (r_state)
            S_FETCH: begin
                instr_req = run;
                ir_load   = run & instr_valid;
                pc_incr   = run & instr_valid;
            end
            S_EXEC: begin
                case (r_op)
                    OP_ADDI: begin
                        add_b_sel = 1'b1;
                        reg_we    = 1'b1;
                    end
                    OP_MUL: begin
                        reg_we    = 1'b1;
                    end
                    OP_IN: begin
                        in_en     = 1'b1;
                        reg_we    = 1'b1;
                    end
                    OP_BRZ: begin
                        add_a_sel = 1'b1;
                        add_b_sel = 1'b1;
                        pc_load   = z;
                    end
                    OP_JMP: begin
                        pc_load   = 1'b1;
                    end
                    OP_MACN: begin
                        acc_en    = w_cnt_nz;
                        rs_step   = w_cnt_nz;
                        reg_we    = w_cnt_last;
                    end
                    default: ;
                endcase
            end
            S_REPEAT: begin
                acc_add = 1'b1;
                acc_en  = 1'b1;
                rs_step = 1'b1;
                reg_we  = w_cnt_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_as_ctrl_seq.sv
// Directed plus randomized check of as_ctrl_seq against an instruction-level trace model.
// Each instruction is expanded into its expected per-cycle control vector sequence.
module tb_as_ctrl_seq;

    localparam int CW = 4;

    localparam logic [12:0] M_REQ  = 13'h1000;
    localparam logic [12:0] M_IRL  = 13'h0800;
    localparam logic [12:0] M_PCI  = 13'h0400;
    localparam logic [12:0] M_PCL  = 13'h0200;
    localparam logic [12:0] M_WE   = 13'h0100;
    localparam logic [12:0] M_AS   = 13'h0080;
    localparam logic [12:0] M_BS   = 13'h0040;
    localparam logic [12:0] M_AE   = 13'h0020;
    localparam logic [12:0] M_AA   = 13'h0010;
    localparam logic [12:0] M_IN   = 13'h0008;
    localparam logic [12:0] M_RS   = 13'h0004;
    localparam logic [12:0] M_BUSY = 13'h0002;
    localparam logic [12:0] M_HLT  = 13'h0001;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          run;
    logic          instr_valid;
    logic [3:0]    opcode;
    logic [CW-1:0] rpt;
    logic          z;
    logic instr_req, ir_load, pc_incr, pc_load, reg_we, add_a_sel, add_b_sel;
    logic acc_en, acc_add, in_en, rs_step, busy, halted;
    logic [12:0]   obs;

    int n_tests = 0;
    int n_fail  = 0;

    as_ctrl_seq #(.n(8), .CW(CW)) dut (
        .clk(clk), .n_reset(n_reset), .run(run), .instr_valid(instr_valid),
        .opcode(opcode), .rpt(rpt), .z(z),
        .instr_req(instr_req), .ir_load(ir_load), .pc_incr(pc_incr), .pc_load(pc_load),
        .reg_we(reg_we), .add_a_sel(add_a_sel), .add_b_sel(add_b_sel), .acc_en(acc_en),
        .acc_add(acc_add), .in_en(in_en), .rs_step(rs_step), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    assign obs = {instr_req, ir_load, pc_incr, pc_load, reg_we, add_a_sel, add_b_sel,
                  acc_en, acc_add, in_en, rs_step, busy, halted};

    // Number of execute cycles an instruction occupies.
    function automatic int exec_len(input logic [3:0] op, input logic [CW-1:0] r);
        return (op == 4'd6 && r > 1) ? int'(r) : 1;
    endfunction

    // Expected controls in execute cycle idx of an instruction.
    function automatic logic [12:0] exec_exp(input logic [3:0] op, input logic [CW-1:0] r,
                                             input logic zv, input int idx);
        logic [12:0] e;
        e = M_BUSY;
        case (op)
            4'd1: e = e | M_BS | M_WE;
            4'd2: e = e | M_WE;
            4'd3: e = e | M_IN | M_WE;
            4'd4: e = e | M_AS | M_BS | (zv ? M_PCL : 13'h0);
            4'd5: e = e | M_PCL;
            4'd6: if (r != 0)
                      e = e | M_AE | M_RS | ((idx > 0) ? M_AA : 13'h0)
                            | ((idx == int'(r) - 1) ? M_WE : 13'h0);
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input logic [12:0] exp, input string tag);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [12:0] exp, input string tag);
        @(negedge clk);
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; returns at the first cycle after the instruction completes.
    task automatic do_instr(input logic [3:0] op, input logic [CW-1:0] r, input int stalls,
                            input int zsel, input bit jitter);
        run = 1'b1;
        for (int s = 0; s < stalls; s++) begin
            instr_valid = 1'b0;
            opcode      = 4'($urandom);
            rpt         = CW'($urandom);
            z           = 1'($urandom);
            step(M_REQ | M_BUSY, "fetch_stall");
        end
        instr_valid = 1'b1;
        opcode      = op;
        rpt         = r;
        step(M_REQ | M_IRL | M_PCI | M_BUSY, $sformatf("fetch_op%0d", op));
        for (int idx = 0; idx < exec_len(op, r); idx++) begin
            instr_valid = 1'($urandom);
            opcode      = 4'($urandom);
            rpt         = CW'($urandom);
            z           = (zsel == 2) ? 1'($urandom) : (zsel == 1);
            run         = jitter ? 1'($urandom) : 1'b1;
            step(exec_exp(op, r, z, idx), $sformatf("exec_op%0d_r%0d_c%0d", op, r, idx));
        end
        run         = 1'b1;
        instr_valid = 1'b0;
    endtask

    task automatic halt_tail();
        run = 1'b1;
        for (int i = 0; i < 3; i++) step(M_HLT, "halt_hold");
        run = 1'b0;
        step(M_HLT, "halt_run0");
        step(13'h0, "idle_after_halt");
        run = 1'b1;
        step(13'h0, "idle_to_fetch");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]    rop;
        logic [CW-1:0] rr;
        int            k;

        n_reset = 1'b0; run = 1'b0; instr_valid = 1'b0; opcode = '0; rpt = '0; z = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(13'h0, "reset");
        n_reset = 1'b1;
        step(13'h0, "idle_run0_a");
        step(13'h0, "idle_run0_b");
        run = 1'b1;
        step(13'h0, "idle_run1");

        do_instr(4'd1, 4'd0, 0, 0, 1'b0);
        do_instr(4'd3, 4'd0, 3, 0, 1'b0);
        do_instr(4'd6, 4'd4, 0, 0, 1'b0);
        do_instr(4'd6, 4'd0, 0, 0, 1'b0);
        do_instr(4'd6, 4'd1, 0, 0, 1'b0);
        do_instr(4'd4, 4'd0, 0, 1, 1'b0);
        do_instr(4'd4, 4'd0, 0, 0, 1'b0);
        do_instr(4'd5, 4'd0, 0, 0, 1'b0);
        do_instr(4'd6, 4'd15, 1, 2, 1'b1);
        do_instr(4'd9, 4'd3, 0, 2, 1'b0);

        run = 1'b0;
        step(M_BUSY, "fetch_run0");
        run = 1'b1;
        step(13'h0, "idle_rerun");

        do_instr(4'd15, 4'd0, 0, 0, 1'b0);
        halt_tail();

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 6)      rop = 4'(k);
            else if (k == 7) rop = 4'd15;
            else             rop = 4'($urandom_range(7, 14));
            rr = CW'($urandom);
            do_instr(rop, rr, $urandom_range(0, 2), 2, 1'b1);
            if (rop == 4'd15) halt_tail();
        end

        // Reset in the middle of a MACN repeat
        run = 1'b1; instr_valid = 1'b1; opcode = 4'd6; rpt = 4'd5;
        step(M_REQ | M_IRL | M_PCI | M_BUSY, "fetch_macn5");
        instr_valid = 1'b0;
        step(exec_exp(4'd6, 4'd5, 1'b0, 0), "macn5_c0");
        step(exec_exp(4'd6, 4'd5, 1'b0, 1), "macn5_c1");
        n_reset = 1'b0;
        #1;
        check(13'h0, "rst_async");
        @(negedge clk);
        check(13'h0, "rst_mid");
        @(posedge clk);
        #1;
        check(13'h0, "rst_hold");
        n_reset = 1'b1;
        step(13'h0, "post_rst_idle");
        step(M_REQ | M_BUSY, "post_rst_fetch");
        do_instr(4'd2, 4'd0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
